shift_serializer: RTL and testbench

- Upstream feeder for the bidirectional shift register (bishift_reg).
- Accepts parallel words plus a direction bit over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word onto the register's d/en/mode inputs: exactly WIDTH consecutive en cycles per word, an optional idle gap, and a one-cycle word_done pulse.

---
 rtl/shift_serializer_pkg.sv | 19 +
 rtl/shift_serializer_fifo.sv | 48 ++++
 rtl/shift_serializer.sv | 139 +++++++++++++
 tb/tb_shift_serializer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the shift_serializer slice: FSM states,
// direction tags and the counter-width helper.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_serializer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; async active-low reset on the
// pointers only, storage is left unreset.
module sync_fifo #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with differing wrap bits means the write side lapped the read side.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/shift_serializer.sv
// Buffers {dir, word} pairs and serializes each word onto d/en/mode for the
// downstream bidirectional shift register, with an optional idle gap.
module shift_serializer
  import shift_pkg::*;
#(
  parameter  int WIDTH      = 4,
  parameter  int DEPTH      = 4,
  parameter  int GAP_CYCLES = 1,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             d,
  output logic             en,
  output logic             mode,
  output logic             word_done,
  output logic             busy,
  output logic [LW-1:0]    level
);

  localparam int CW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_CYCLES);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic             dir_q, dir_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [GW-1:0]    gcnt, gcnt_nx;
  logic             done_q, done_nx;
  logic             ready_en;
  logic             load;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [WIDTH:0]   fifo_rdata;

  assign push     = in_valid && in_ready;
  assign in_ready = ready_en && !full;

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_dir, in_data}),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sh     <= '0;
      dir_q  <= DIR_MSB_FIRST;
      cnt    <= '0;
      gcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      sh     <= sh_nx;
      dir_q  <= dir_nx;
      cnt    <= cnt_nx;
      gcnt   <= gcnt_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    dir_nx   = dir_q;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    done_nx  = 1'b0;
    load     = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        load = !empty;
      end
      SHIFT: begin
        sh_nx  = (dir_q == DIR_LSB_FIRST) ? (sh >> 1) : (sh << 1);
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          done_nx = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_nx = GAP;
            gcnt_nx  = '0;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt == GW'(GAP_CYCLES - 1)) begin
          if (!empty) load = 1'b1;
          else        state_nx = IDLE;
        end else begin
          gcnt_nx = gcnt + GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // Every path that starts a word shares one pop/load so the holder,
    // direction and counter always change together.
    if (load) begin
      pop      = 1'b1;
      sh_nx    = fifo_rdata[WIDTH-1:0];
      dir_nx   = fifo_rdata[WIDTH];
      cnt_nx   = '0;
      state_nx = SHIFT;
    end
  end

  assign en        = (state == SHIFT);
  assign busy      = (state != IDLE);
  assign mode      = dir_q;
  assign word_done = done_q;
  assign d         = (state == SHIFT) && ((dir_q == DIR_LSB_FIRST) ? sh[0] : sh[WIDTH-1]);

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: two instances (gap of 1 and back-to-back) checked
// by directed steps plus random traffic against a transaction-level model.
module tb_shift_serializer;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int SBN   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] in_valid = '0;
  logic [1:0] in_dir = '0;
  logic [1:0] in_ready, d, en, mode, wd, busy;
  logic [W-1:0]  in_data [2];
  logic [LW-1:0] level [2];

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  shift_serializer #(.WIDTH(W), .DEPTH(DEPTH), .GAP_CYCLES(1)) u_gap1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_dir(in_dir[0]), .d(d[0]), .en(en[0]), .mode(mode[0]),
    .word_done(wd[0]), .busy(busy[0]), .level(level[0])
  );

  shift_serializer #(.WIDTH(W), .DEPTH(DEPTH), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_dir(in_dir[1]), .d(d[1]), .en(en[1]), .mode(mode[1]),
    .word_done(wd[1]), .busy(busy[1]), .level(level[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model: accepted words and pops ----------------
  logic [W:0] txa [2][SBN];
  logic [W:0] rxa [2][SBN];
  int txn [2];
  int rxn [2];
  int pushes [2];
  int started [2];
  bit armed [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        pushes[k] = 0; txn[k] = 0; armed[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k] && in_ready[k] && txn[k] < SBN) begin
          txa[k][txn[k]] = {in_dir[k], in_data[k]};
          txn[k]++;
          pushes[k]++;
        end
        armed[k] = 1'b1;
      end
    end
  end

  // Output monitor: rebuilds words the way the downstream register would,
  // and tallies protocol violations per instance.
  logic [W-1:0] q [2];
  logic wmode [2];
  bit last_bit [2];
  int nb [2];
  int wd_err [2], mode_err [2], d_err [2], busy_err [2], lvl_err [2], rdy_err [2];
  int max_lvl [2], stalls [2];
  int expl;
  logic eb;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        nb[k] = 0; last_bit[k] = 1'b0; started[k] = 0; rxn[k] = 0;
      end else begin
        if (wd[k] !== last_bit[k]) wd_err[k]++;
        eb = en[k] | ((k == 0) ? wd[k] : 1'b0);
        if (busy[k] !== eb) busy_err[k]++;
        last_bit[k] = 1'b0;
        if (en[k] === 1'b1) begin
          if (nb[k] == 0) begin
            started[k]++;
            wmode[k] = mode[k];
          end else if (mode[k] !== wmode[k]) begin
            mode_err[k]++;
          end
          q[k] = mode[k] ? {d[k], q[k][W-1:1]} : {q[k][W-2:0], d[k]};
          nb[k]++;
          if (nb[k] == W) begin
            if (rxn[k] < SBN) rxa[k][rxn[k]] = {wmode[k], q[k]};
            rxn[k]++;
            nb[k] = 0;
            last_bit[k] = 1'b1;
          end
        end else if (d[k] !== 1'b0) begin
          d_err[k]++;
        end
        expl = pushes[k] - started[k];
        if (int'(level[k]) !== expl) lvl_err[k]++;
        if (in_ready[k] !== (armed[k] && expl != DEPTH)) rdy_err[k]++;
        if (int'(level[k]) > max_lvl[k]) max_lvl[k] = int'(level[k]);
        if (!in_ready[k] && in_valid[k] && armed[k]) stalls[k]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit [1:0] rdy_seen = '0;

  // One cycle of upstream traffic; an unaccepted word is held unchanged.
  task automatic step(input int pct0, input int pct1);
    int pct;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      pct = (k == 0) ? pct0 : pct1;
      if (!in_valid[k] || rdy_seen[k]) begin
        in_valid[k] = ($urandom_range(99) < pct);
        in_data[k]  = W'($urandom);
        in_dir[k]   = 1'($urandom);
      end
      rdy_seen[k] = in_ready[k];
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    do begin
      step(0, 0);
      n++;
    end while ((in_valid != 0 || busy != 0 || en != 0 || wd != 0 ||
                level[0] != 0 || level[1] != 0) && n < 400);
    check(tag, 32'(n < 400), 1);
  endtask

  task automatic single(input int k, input logic [W-1:0] w, input logic dir);
    logic [W-1:0] seq, exp_seq;
    for (int j = 0; j < W; j++) exp_seq[W-1-j] = dir ? w[j] : w[W-1-j];
    seq = '0;
    @(negedge clk);
    in_valid[k] = 1'b1; in_data[k] = w; in_dir[k] = dir;
    @(negedge clk);
    in_valid[k] = 1'b0;
    check("one_wait_en", en[k], 0);
    check("one_wait_lvl", level[k], 1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("one_en", en[k], 1);
      check("one_mode", mode[k], dir);
      check("one_busy", busy[k], 1);
      seq = {seq[W-2:0], d[k]};
    end
    check("one_dseq", seq, exp_seq);
    @(negedge clk);
    check("one_done_en", en[k], 0);
    check("one_done", wd[k], 1);
    check("one_gap_busy", busy[k], (k == 0) ? 1 : 0);
    @(negedge clk);
    check("one_done_low", wd[k], 0);
    check("one_idle_busy", busy[k], 0);
  endtask

  task automatic compare(input int k);
    check("sb_count", rxn[k], txn[k]);
    for (int i = 0; i < txn[k] && i < rxn[k] && i < SBN; i++)
      check("sb_word", rxa[k][i], txa[k][i]);
  endtask

  initial begin
    logic [7:0] seq8;
    int cnt_en;
    in_data[0] = '0; in_data[1] = '0;

    // Reset values while held in reset across clock edges
    repeat (2) @(negedge clk);
    check("rst_en", en, 0);
    check("rst_d", d, 0);
    check("rst_mode", mode, 0);
    check("rst_wd", wd, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_lvl0", level[0], 0);
    check("rst_lvl1", level[1], 0);
    rst = 1'b1;
    #1 check("ready_pre_edge", in_ready, 0);
    @(negedge clk);
    check("ready_post_edge", in_ready, 2'b11);

    // Single words, both directions, on both gap settings
    single(0, 4'b1011, 1'b0);
    single(0, 4'b1011, 1'b1);
    single(1, 4'b0110, 1'b1);

    // Back-to-back with no gap: 0xA then 0x5, MSB first
    @(negedge clk);
    in_valid[1] = 1'b1; in_data[1] = 4'hA; in_dir[1] = 1'b0;
    @(negedge clk);
    in_data[1] = 4'h5;
    @(negedge clk);
    in_valid[1] = 1'b0;
    seq8 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check("b2b_en", en[1], 1);
      check("b2b_mode", mode[1], 0);
      check("b2b_wd", wd[1], (i == 4) ? 1 : 0);
      seq8 = {seq8[6:0], d[1]};
    end
    check("b2b_dseq", seq8, 8'hA5);
    @(negedge clk);
    check("b2b_end_en", en[1], 0);
    check("b2b_end_wd", wd[1], 1);
    drain("drain_b2b");

    // Push coinciding with a pop at level 2 keeps the level at 2
    @(negedge clk); in_valid[1] = 1'b1; in_data[1] = W'($urandom); in_dir[1] = 1'b0;
    @(negedge clk); in_data[1] = W'($urandom);
    @(negedge clk); in_data[1] = W'($urandom);
    @(negedge clk); in_valid[1] = 1'b0;
    check("pp_lvl_a", level[1], 2);
    @(negedge clk);
    check("pp_lvl_b", level[1], 2);
    @(negedge clk);
    in_valid[1] = 1'b1; in_data[1] = W'($urandom); in_dir[1] = 1'b1;
    check("pp_lvl_c", level[1], 2);
    @(negedge clk);
    in_valid[1] = 1'b0;
    check("pp_lvl_d", level[1], 2);
    check("pp_en", en[1], 1);
    drain("drain_pp");

    // Fill: valid held high on the gap-1 instance until it back-pressures
    rdy_seen = '0;
    repeat (16) step(100, 0);
    check("fill_max_lvl", max_lvl[0], DEPTH);
    check("fill_stalled", 32'(stalls[0] > 0), 1);
    drain("drain_fill");

    // Random traffic on both instances
    repeat (400) step(60, 60);
    drain("drain_rand");
    compare(0);
    compare(1);

    // Reset in the middle of a word
    @(negedge clk);
    in_valid = 2'b11; in_data[0] = W'($urandom); in_data[1] = W'($urandom); in_dir = 2'($urandom);
    @(negedge clk); in_valid[1] = 1'b0; in_data[0] = W'($urandom);
    @(negedge clk); in_data[0] = W'($urandom);
    @(negedge clk); in_valid = '0;
    @(negedge clk);
    check("mid_en_pre", en, 2'b11);
    check("mid_lvl_pre", level[0], 2);
    #2 rst = 1'b0;
    #1;
    check("mid_en", en, 0);
    check("mid_busy", busy, 0);
    check("mid_d", d, 0);
    check("mid_wd", wd, 0);
    check("mid_ready", in_ready, 0);
    check("mid_lvl0", level[0], 0);
    check("mid_lvl1", level[1], 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rdy_seen = '0;
    cnt_en = 0;
    repeat (12) begin
      step(0, 0);
      if (en != 0 || busy != 0) cnt_en++;
    end
    check("post_rst_quiet", cnt_en, 0);
    check("post_rst_ready", in_ready, 2'b11);
    single(0, 4'b1101, 1'b0);
    drain("drain_final");
    compare(0);
    compare(1);

    for (int k = 0; k < 2; k++) begin
      check("mon_word_done", wd_err[k], 0);
      check("mon_mode_stable", mode_err[k], 0);
      check("mon_d_idle", d_err[k], 0);
      check("mon_busy", busy_err[k], 0);
      check("mon_level", lvl_err[k], 0);
      check("mon_ready", rdy_err[k], 0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
